// File: rtl/div_if.sv
// Execute-to-divider port bundle: operand issue, abort and result return.
// master = execute stage, slave = divider.
interface div_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per clock,
// result {remainder, quotient} held until execute drops start_i.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]    dvd_q, dvd_d;      // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]    dvs_q, dvs_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic                sgn_q, sgn_d;
  logic                neg1_q, neg1_d;
  logic                neg2_q, neg2_d;
  logic [2*WIDTH-1:0]  result_q, result_d;
  logic                ready_q, ready_d;

  logic [WIDTH:0]      rem_shift_s;
  logic [WIDTH:0]      diff_s;
  logic                qbit_s;
  logic [WIDTH-1:0]    rem_iter_s;
  logic [WIDTH-1:0]    quot_iter_s;
  logic [WIDTH-1:0]    quot_fix_s;
  logic [WIDTH-1:0]    rem_fix_s;
  logic [WIDTH-1:0]    op1_abs_s;
  logic [WIDTH-1:0]    op2_abs_s;

  // Operand magnitudes and one restoring-division step.
  always_comb begin
    op1_abs_s = (bus.signed_div_i && bus.opdata1_i[WIDTH-1])
                ? ({WIDTH{1'b0}} - bus.opdata1_i) : bus.opdata1_i;
    op2_abs_s = (bus.signed_div_i && bus.opdata2_i[WIDTH-1])
                ? ({WIDTH{1'b0}} - bus.opdata2_i) : bus.opdata2_i;

    rem_shift_s = {rem_q, dvd_q[WIDTH-1]};
    diff_s      = rem_shift_s - {1'b0, dvs_q};
    qbit_s      = ~diff_s[WIDTH];
    rem_iter_s  = qbit_s ? diff_s[WIDTH-1:0] : rem_shift_s[WIDTH-1:0];
    quot_iter_s = {dvd_q[WIDTH-2:0], qbit_s};

    // Truncating division: quotient sign from XOR, remainder follows dividend.
    quot_fix_s = (sgn_q && (neg1_q ^ neg2_q))
                 ? ({WIDTH{1'b0}} - quot_iter_s) : quot_iter_s;
    rem_fix_s  = (sgn_q && neg1_q)
                 ? ({WIDTH{1'b0}} - rem_iter_s) : rem_iter_s;
  end

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    sgn_d    = sgn_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = ready_q;

    case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = {(2*WIDTH){1'b0}};
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == {WIDTH{1'b0}}) begin
            state_d = BYZERO;
          end else begin
            state_d = ON;
            cnt_d   = {CW{1'b0}};
            dvd_d   = op1_abs_s;
            dvs_d   = op2_abs_s;
            rem_d   = {WIDTH{1'b0}};
            sgn_d   = bus.signed_div_i;
            neg1_d  = bus.opdata1_i[WIDTH-1];
            neg2_d  = bus.opdata2_i[WIDTH-1];
          end
        end else begin
          state_d = FREE;
        end
      end

      BYZERO: begin
        state_d  = END;
        result_d = {(2*WIDTH){1'b0}};
        ready_d  = 1'b1;
      end

      ON: begin
        if (bus.annul_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = {(2*WIDTH){1'b0}};
        end else begin
          cnt_d = cnt_q + CW'(1);
          rem_d = rem_iter_s;
          dvd_d = quot_iter_s;
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_d  = END;
            result_d = {rem_fix_s, quot_fix_s};
            ready_d  = 1'b1;
          end else begin
            state_d = ON;
          end
        end
      end

      END: begin
        if (bus.start_i && !bus.annul_i) begin
          state_d = END;
        end else begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = {(2*WIDTH){1'b0}};
        end
      end

      default: begin
        state_d  = FREE;
        ready_d  = 1'b0;
        result_d = {(2*WIDTH){1'b0}};
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= {CW{1'b0}};
      dvd_q    <= {WIDTH{1'b0}};
      dvs_q    <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      sgn_q    <= 1'b0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= {(2*WIDTH){1'b0}};
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      sgn_q    <= sgn_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: driver pushes expected results and
// ready edge numbers into a queue; a monitor pops and compares on ready.
module tb_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [63:0] res;
    int          edge_n;
  } exp_t;

  exp_t exp_q[$];

  div_if #(.WIDTH(32)) bus();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard pop on ready rise, plus output invariants.
  initial begin
    logic        ready_prev;
    logic [63:0] held;
    exp_t        e;
    ready_prev = 1'b0;
    held       = 64'h0;
    forever begin
      @(negedge clk);
      if (bus.ready_o && !ready_prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ready at edge %0d: result %h, no operation outstanding", cyc, bus.result_o);
        end else begin
          e = exp_q.pop_front();
          if (bus.result_o !== e.res) begin
            errors++;
            $display("FAIL result at edge %0d: got %h expected %h", cyc, bus.result_o, e.res);
          end
          checks++;
          if (cyc != e.edge_n) begin
            errors++;
            $display("FAIL latency: ready rose at edge %0d expected edge %0d", cyc, e.edge_n);
          end
        end
        held = bus.result_o;
      end else if (bus.ready_o) begin
        checks++;
        if (bus.result_o !== held) begin
          errors++;
          $display("FAIL stable: result %h changed from %h while ready", bus.result_o, held);
        end
      end else begin
        checks++;
        if (bus.result_o !== 64'h0) begin
          errors++;
          $display("FAIL idle_zero: result %h while not ready, expected 0", bus.result_o);
        end
      end
      ready_prev = bus.ready_o;
    end
  end

  task automatic check_idle(input string name);
    checks++;
    if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
      errors++;
      $display("FAIL %s: ready %b result %h, expected ready 0 result 0", name, bus.ready_o, bus.result_o);
    end
  endtask

  // Issue one division, scramble operands after the start edge, hold start, release.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] res, input int hold);
    exp_t e;
    int   i;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    bus.annul_i      = 1'b0;
    e.res    = res;
    e.edge_n = cyc + 1 + ((b == 32'h0) ? 1 : 32);
    exp_q.push_back(e);
    @(negedge clk);
    bus.opdata1_i = ~a;
    bus.opdata2_i = b ^ 32'h5A5A_0001;
    i = 0;
    while (!bus.ready_o && i < 100) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (!bus.ready_o) begin
      errors++;
      $display("FAIL timeout: ready not seen for %h / %h", a, b);
    end
    repeat (hold) @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    check_idle("clear_after_start_low");
  endtask

  initial begin
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'h0;
    bus.opdata2_i    = 32'h0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle_after_reset");

    run_div(1'b0, 32'd7,          32'd2,          64'h00000001_00000003, 4);
    run_div(1'b1, 32'hFFFFFFF9,   32'h00000002,   64'hFFFFFFFF_FFFFFFFD, 1);
    run_div(1'b1, 32'h00000007,   32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 1);
    run_div(1'b0, 32'h12345678,   32'h00000000,   64'h00000000_00000000, 2);
    run_div(1'b0, 32'hFFFFFFFF,   32'h00000001,   64'h00000000_FFFFFFFF, 1);
    run_div(1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 1);
    run_div(1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000, 1);

    // Annul while cnt == 10: no result may ever appear.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd1000;
    bus.opdata2_i    = 32'd3;
    bus.start_i      = 1'b1;
    repeat (11) @(negedge clk);
    bus.annul_i = 1'b1;
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    check_idle("after_annul");
    repeat (40) @(negedge clk);
    check_idle("annul_no_ready");
    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1);

    // Reset pulse while cnt == 20.
    @(negedge clk);
    bus.signed_div_i = 1'b1;
    bus.opdata1_i    = 32'hFFFFFF00;
    bus.opdata2_i    = 32'd5;
    bus.start_i      = 1'b1;
    repeat (21) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start_i = 1'b0;
    check_idle("after_mid_reset");
    repeat (40) @(negedge clk);
    check_idle("reset_no_ready");
    run_div(1'b1, 32'hFFFFFF9C, 32'd7, 64'hFFFFFFFE_FFFFFFF2, 2);

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected results never seen, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
